pwm_dac_gen: RTL and testbench

PWM DAC engine downstream of the 2-bit frequency-select PIO register. The PIO's out_port drives freq_sel, which picks one of four PWM period lengths. Duty samples arrive over a valid/ready stream, are double-buffered, and are applied only at PWM period boundaries. The block drives the PWM pin that feeds the external RC reconstruction filter.

---
 rtl/pwm_dac_gen.sv | 138 +++++++++++++
 tb/tb_pwm_dac_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_gen.sv
// PWM DAC engine: double-buffered duty samples are applied at period boundaries, with four prescaled period lengths.
// Optional complementary output with dead-time when PWM_DAC_COMPL_EN is defined.
module pwm_dac_gen #(
    parameter int RES_BITS = 8,
    parameter int PRESC0   = 1,
    parameter int PRESC1   = 2,
    parameter int PRESC2   = 4,
`ifdef PWM_DAC_COMPL_EN
    parameter int PRESC3   = 8,
    parameter int DEAD_CYC = 2
`else
    parameter int PRESC3   = 8
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          freq_sel,
    input  logic [RES_BITS-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                underrun_clr,
    output logic                pwm_out,
`ifdef PWM_DAC_COMPL_EN
    output logic                pwm_out_n,
`endif
    output logic                period_tick,
    output logic                underrun
);

    localparam int PW = 16;

    logic [PW-1:0]       presc_cnt;
    logic [PW-1:0]       presc_term;
    logic [RES_BITS-1:0] pwm_cnt;
    logic [RES_BITS-1:0] duty_act;
    logic [RES_BITS-1:0] duty_buf;
    logic                buf_full;
    logic [1:0]          sel_act;
    logic                cnt_en;
    logic                pend;
    logic                xfer;
    logic                raw;

    always_comb begin
        presc_term = '0;
        case (sel_act)
            2'd0:    presc_term = PW'(PRESC0 - 1);
            2'd1:    presc_term = PW'(PRESC1 - 1);
            2'd2:    presc_term = PW'(PRESC2 - 1);
            default: presc_term = PW'(PRESC3 - 1);
        endcase
    end

    assign cnt_en       = (presc_cnt == presc_term);
    assign pend         = cnt_en && (pwm_cnt == '1);
    assign sample_ready = ~buf_full;
    assign xfer         = sample_valid && ~buf_full;
    assign raw          = (pwm_cnt < duty_act);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= cnt_en ? '0 : presc_cnt + 1'b1;
            if (cnt_en)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // An empty buffer at period end takes a same-cycle sample directly; otherwise the period underruns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_act    <= '0;
            duty_buf    <= '0;
            buf_full    <= 1'b0;
            sel_act     <= '0;
            underrun    <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            period_tick <= pend;
            if (pend) begin
                sel_act <= freq_sel;
                if (buf_full) begin
                    duty_act <= duty_buf;
                    buf_full <= 1'b0;
                end else if (xfer) begin
                    duty_act <= sample_data;
                end
            end else if (xfer) begin
                duty_buf <= sample_data;
                buf_full <= 1'b1;
            end
            if (pend && !buf_full && !xfer)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

`ifdef PWM_DAC_COMPL_EN
    localparam int DW = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC + 1);

    logic          raw_q;
    logic [DW-1:0] dead_cnt;
    logic [DW-1:0] dead_nxt;

    always_comb begin
        dead_nxt = '0;
        if (raw != raw_q)
            dead_nxt = DW'(DEAD_CYC);
        else if (dead_cnt != '0)
            dead_nxt = dead_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q     <= 1'b0;
            dead_cnt  <= '0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            raw_q     <= raw;
            dead_cnt  <= dead_nxt;
            pwm_out   <= (dead_nxt == '0) && raw;
            pwm_out_n <= (dead_nxt == '0) && !raw;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pwm_out <= 1'b0;
        else
            pwm_out <= raw;
    end
`endif

endmodule

// File: tb/tb_pwm_dac_gen.sv
// Directed bench for pwm_dac_gen: a duty/period vector table plus hand-written boundary sequences.
module tb_pwm_dac_gen;

    localparam int DEAD = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] freq_sel = 2'd0;
    logic [7:0] sample_data = '0;
    logic       sample_valid = 1'b0;
    logic       sample_ready;
    logic       underrun_clr = 1'b0;
    logic       pwm_out;
    logic       period_tick;
    logic       underrun;
`ifdef PWM_DAC_COMPL_EN
    logic       pwm_out_n;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_dac_gen #(.RES_BITS(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .freq_sel     (freq_sel),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .pwm_out      (pwm_out),
`ifdef PWM_DAC_COMPL_EN
        .pwm_out_n    (pwm_out_n),
`endif
        .period_tick  (period_tick),
        .underrun     (underrun)
    );

    typedef struct {
        logic [7:0] duty;
        logic [1:0] sel;
        int         len;
        int         high;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Expected pwm_out high count given the raw high count h in a period.
    function automatic int exp_out(input int h);
`ifdef PWM_DAC_COMPL_EN
        return (h <= DEAD) ? 0 : h - DEAD;
`else
        return h;
`endif
    endfunction

    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 6000);
        if (!period_tick) timeout(name);
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
        while (!sample_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) timeout("push");
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Starts on a period_tick sample; counts samples up to and including the next tick.
    task automatic measure(input bit refill, input logic [7:0] d, input int sw_at, input logic [1:0] sw_sel,
                           output int len, output int high, output int nhigh, output int ovl);
        len = 0; high = 0; nhigh = 0; ovl = 0;
        do begin
            @(negedge clk);
            len++;
            if (pwm_out) high++;
`ifdef PWM_DAC_COMPL_EN
            if (pwm_out_n) nhigh++;
            if (pwm_out && pwm_out_n) ovl++;
`endif
            if (len == 1) begin
                sample_valid = refill;
                sample_data  = d;
                underrun_clr = 1'b1;
            end else if (len == 2) begin
                sample_valid = 1'b0;
                underrun_clr = 1'b0;
            end
            if (sw_at != 0 && len == sw_at) freq_sel = sw_sel;
        end while (!period_tick && len < 6000);
        if (!period_tick) timeout("measure");
    endtask

    initial begin
        int len, high, nhigh, ovl, n;

        vecs[0] = '{8'h40, 2'd0, 256, 64};
        vecs[1] = '{8'h80, 2'd0, 256, 128};
        vecs[2] = '{8'hFF, 2'd0, 256, 255};
        vecs[3] = '{8'h00, 2'd0, 256, 0};
        vecs[4] = '{8'h80, 2'd2, 1024, 512};
        vecs[5] = '{8'h40, 2'd1, 512, 128};
        vecs[6] = '{8'h01, 2'd3, 2048, 8};
        vecs[7] = '{8'hC0, 2'd3, 2048, 1536};
        vecs[8] = '{8'h01, 2'd0, 256, 1};
        vecs[9] = '{8'h40, 2'd0, 256, 64};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        chk("rst_underrun", int'(underrun), 0);
`ifdef PWM_DAC_COMPL_EN
        chk("rst_pwm_n", int'(pwm_out_n), 0);
`endif

        // First period with no samples: tick at 256, underrun set
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 6000);
        chk("first_tick_cycle", n, 256);
        chk("first_underrun", int'(underrun), 1);
        measure(1'b0, 8'h00, 0, 2'd0, len, high, nhigh, ovl);
        chk("idle_len", len, 256);
        chk("idle_high", high, 0);
        chk("idle_underrun_reset", int'(underrun), 1);
        @(negedge clk); underrun_clr = 1'b1;
        @(negedge clk); underrun_clr = 1'b0;
        chk("underrun_cleared", int'(underrun), 0);
        wait_tick("idle_tick");
        chk("underrun_reset_again", int'(underrun), 1);

        // Back-to-back samples: second waits for the period end
        repeat (20) @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = 8'h10;
        @(negedge clk);
        chk("b2b_ready_low", int'(sample_ready), 0);
        sample_data = 8'h20;
        n = 0;
        while (!sample_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_at_pend", int'(period_tick), 1);
        measure(1'b0, 8'h00, 0, 2'd0, len, high, nhigh, ovl);
        chk("b2b_first_high", high, exp_out(16));
        chk("b2b_first_underrun", int'(underrun), 0);
        measure(1'b0, 8'h00, 0, 2'd0, len, high, nhigh, ovl);
        chk("b2b_second_high", high, exp_out(32));
        chk("b2b_second_underrun", int'(underrun), 1);

        // Underrun set wins over a clear held across the period end
        underrun_clr = 1'b1;
        repeat (10) @(negedge clk);
        chk("clr_held_mid", int'(underrun), 0);
        wait_tick("clr_held_tick");
        chk("clr_held_pend_set", int'(underrun), 1);
        underrun_clr = 1'b0;

        // Mid-period freq_sel change completes the current period at the old rate
        push(8'h80);
        wait_tick("sw_apply");
        measure(1'b1, 8'h80, 100, 2'd2, len, high, nhigh, ovl);
        chk("sw_old_len", len, 256);
        chk("sw_old_high", high, exp_out(128));
        measure(1'b1, 8'h80, 0, 2'd0, len, high, nhigh, ovl);
        chk("sw_new_len", len, 1024);
        chk("sw_new_high", high, exp_out(512));

        // Table of duty/period vectors, refilling each measured period
        for (int unsigned i = 0; i < 10; i++) begin
            freq_sel = vecs[i].sel;
            push(vecs[i].duty);
            wait_tick("vec_apply");
            measure(1'b1, vecs[i].duty, 0, 2'd0, len, high, nhigh, ovl);
            chk($sformatf("vec%0d_len", i), len, vecs[i].len);
            chk($sformatf("vec%0d_high", i), high, exp_out(vecs[i].high));
            chk($sformatf("vec%0d_underrun", i), int'(underrun), 0);
`ifdef PWM_DAC_COMPL_EN
            chk($sformatf("vec%0d_overlap", i), ovl, 0);
            if (vecs[i].high > 0 && vecs[i].len - vecs[i].high > DEAD)
                chk($sformatf("vec%0d_n_high", i), nhigh, vecs[i].len - vecs[i].high - DEAD);
`endif
        end

        // Reset mid-operation discards the pending sample
        push(8'hA0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_pwm", int'(pwm_out), 0);
        chk("midrst_ready", int'(sample_ready), 1);
        chk("midrst_underrun", int'(underrun), 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 6000);
        chk("midrst_first_tick", n, 256);
        measure(1'b0, 8'h00, 0, 2'd0, len, high, nhigh, ovl);
        chk("midrst_high", high, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
